// File: rtl/layer_sequencer.sv
// Per-layer sequencer: launches the shared neuron once per output, captures each sum,
// applies ReLU/shift/saturate into an output buffer. Optional argmax tracking: LAYER_ARGMAX_EN.
module layer_sequencer #(
   parameter int M     = 10,
   parameter int SUM_W = 20,
   parameter int OUT_W = 8,
   parameter int SHIFT = 4,
   localparam int IDX_W = (M > 1) ? $clog2(M) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             layer_start,
   output logic             neuron_start,
   output logic [IDX_W-1:0] neuron_sel,
   input  logic             neuron_ready,
   input  logic [SUM_W-1:0] neuron_sum,
   input  logic [IDX_W-1:0] rd_addr,
   output logic [OUT_W-1:0] rd_data,
   output logic             layer_busy,
   output logic             layer_done
`ifdef LAYER_ARGMAX_EN
   ,
   output logic [IDX_W-1:0] max_idx
`endif
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LAUNCH = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_STORE  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam logic [SUM_W-1:0] SAT_LIM = SUM_W'((1 << OUT_W) - 1);

   logic [2:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [OUT_W-1:0] buf_q [M];
   logic [OUT_W-1:0] act_val;
   logic             last_idx;

   // Shift is done at full sum width so large sums saturate instead of wrapping.
   function automatic logic [OUT_W-1:0] act(input logic [SUM_W-1:0] s);
      logic signed [SUM_W-1:0] t;
      t = $signed(s) >>> SHIFT;
      if (s[SUM_W-1])
         act = '0;
      else if ($unsigned(t) > SAT_LIM)
         act = '1;
      else
         act = t[OUT_W-1:0];
   endfunction

   assign act_val  = act(sum_q);
   assign last_idx = (idx_q == IDX_W'(M - 1));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      case (state_q)
         S_IDLE: begin
            if (layer_start) begin
               state_d = S_LAUNCH;
               idx_d   = '0;
            end
         end
         S_LAUNCH: state_d = S_WAIT;
         S_WAIT: begin
            if (neuron_ready) begin
               sum_d   = neuron_sum;
               state_d = S_STORE;
            end
         end
         S_STORE: begin
            if (last_idx) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_LAUNCH;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
      end
   end

   // One register per entry so reset can clear the whole buffer at once.
   genvar gi;
   generate
      for (gi = 0; gi < M; gi++) begin : g_buf
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               buf_q[gi] <= '0;
            else if (state_q == S_STORE && idx_q == IDX_W'(gi))
               buf_q[gi] <= act_val;
         end
      end
   endgenerate

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < M; i++) begin
         if (rd_addr == IDX_W'(i))
            rd_data = buf_q[i];
      end
   end

   assign neuron_start = (state_q == S_LAUNCH);
   assign neuron_sel   = idx_q;
   assign layer_busy   = (state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_STORE);
   assign layer_done   = (state_q == S_DONE);

`ifdef LAYER_ARGMAX_EN
   logic [OUT_W-1:0] max_val_q;
   logic [IDX_W-1:0] max_idx_q;

   // Strict compare keeps the lower index on ties.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         max_val_q <= '0;
         max_idx_q <= '0;
      end else if (state_q == S_STORE && (idx_q == '0 || act_val > max_val_q)) begin
         max_val_q <= act_val;
         max_idx_q <= idx_q;
      end
   end

   assign max_idx = max_idx_q;
`endif

endmodule
